// File: rtl/div_unit_p.sv
// Multi-cycle restoring integer divider with start/busy/done handshake and abort.
// Define DIV_EARLY_TERM_EN to skip leading zero bits of the dividend magnitude.
module div_unit_p #(
  parameter int WIDTH = 32
) (
  input  logic             wb_clk_i,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic             want_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_a_q, neg_b_q, rem_sel_q, dbz_q;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b, quo_load;
  logic [CW-1:0]    steps;
  logic [WIDTH:0]   part;
  logic             ge;
  logic [WIDTH-1:0] rem_d, quo_d, quo_fin, rem_fin;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

`ifdef DIV_EARLY_TERM_EN
  logic [CW-1:0] lz;

  function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction
`endif

  always_comb begin
    sgn_a = is_signed & dividend[WIDTH-1];
    sgn_b = is_signed & divisor[WIDTH-1];
    mag_a = cneg(dividend, sgn_a);
    mag_b = cneg(divisor, sgn_b);
`ifdef DIV_EARLY_TERM_EN
    // Pre-shift so the first CALC step already sees the top set bit.
    lz       = lzc(mag_a);
    steps    = (lz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - lz;
    quo_load = mag_a << (CW'(WIDTH) - steps);
`else
    steps    = CW'(WIDTH);
    quo_load = mag_a;
`endif
    // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
    part    = {rem_q, quo_q[WIDTH-1]};
    ge      = part >= {1'b0, dvs_q};
    rem_d   = ge ? (part[WIDTH-1:0] - dvs_q) : part[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ge};
    quo_fin = dbz_q ? quo_q : cneg(quo_q, neg_a_q ^ neg_b_q);
    rem_fin = cneg(rem_q, neg_a_q);
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      rem_sel_q   <= 1'b0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            dvs_q     <= mag_b;
            neg_a_q   <= sgn_a;
            neg_b_q   <= sgn_b;
            rem_sel_q <= want_rem;
            cnt_q     <= steps;
            if (divisor == '0) begin
              // Remainder path re-applies the sign, restoring the raw dividend.
              dbz_q   <= 1'b1;
              rem_q   <= mag_a;
              quo_q   <= '1;
              state_q <= FIXUP;
            end else begin
              dbz_q   <= 1'b0;
              rem_q   <= '0;
              quo_q   <= quo_load;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= FIXUP;
          end
        end
        FIXUP: begin
          if (!abort) begin
            result      <= rem_sel_q ? rem_fin : quo_fin;
            div_by_zero <= dbz_q;
            done        <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
